scaled_pixel_generator: RTL and testbench
=========================================

// Module: scaled_pixel_generator
// PURPOSE
//  Next-generation pixel generator. Holds a COLS x ROWS indexed framebuffer and a
//  2**BPP-entry palette. It scales each cell by X_SCALE x Y_SCALE and drives o_color
//  to the VGA output stage. Instructions arrive on a 32-bit valid/ready port.
//  Additions: SET_PIXEL, SET_PALETTE, a multi-cycle FILL, and a border colour.
// PARAMETERS
//  COLS     80  framebuffer columns (<=256)
//  ROWS     60  framebuffer rows (<=256)
//  BPP      3   bits per cell; palette depth 2**BPP (1..8)
//  X_SCALE  8   screen pixels per cell horizontally (>=1)
//  Y_SCALE  8   screen lines per cell vertically (>=1)
//  COLOR_W  12  output colour width
// PORTS
//  i_clk                in  1        clock
//  i_reset              in  1        reset, asynchronous, active-high
//  i_frame_start        in  1        1-cycle pulse: start of frame (vsync)
//  i_line_end           in  1        1-cycle pulse: end of visible line (hsync)
//  i_pixel_en           in  1        1-cycle pulse per visible screen pixel
//  o_color              out COLOR_W  registered pixel colour
//  i_instruction        in  32       [7:0] opcode, [31:8] args
//  i_instruction_valid  in  1        instruction present
//  o_instruction_ready  out 1        block can accept an instruction
// BEHAVIOUR
//  Reset: o_color=0, bg_color=pending_bg=0, all scan counters 0, state IDLE.
//   o_instruction_ready=1; fill counter 0. Palette[i]=default table
//   {000,fff,f00,0f0,00f,f0f,0ff,ff0} for i<8, 0 otherwise. Framebuffer is not reset
//   (initialised to 0 at configuration). Reset asserted mid-FILL aborts the fill.
//  Handshake: transfer when valid&&ready. Ready=1 in IDLE, 0 in FILL.
//  Opcodes (all accepted on transfer; unknown opcodes are dropped silently):
//   01 SET_BG: pending_bg<=args[11:0]; copied to bg_color on i_frame_start.
//   07 SET_PIXEL: x=[15:8], y=[23:16], idx=[24+:BPP]. Writes fb[y*COLS+x].
//      Ignored if x>=COLS or y>=ROWS.
//   08 SET_PALETTE: colour=[8+:COLOR_W], entry=[20+:BPP]; write takes effect next cycle.
//   09 FILL: idx=[8+:BPP]; state->FILL. Writes one cell/cycle at addresses
//      0..COLS*ROWS-1, then IDLE. FILL occupies exactly COLS*ROWS cycles with ready=0.
//  Scan: counters x_sub/col/y_sub/row.
//   On i_pixel_en: x_sub++. When x_sub wraps at X_SCALE: x_sub=0, col++.
//   col saturates at COLS.
//   On i_line_end: x_sub=col=0; y_sub++. When y_sub wraps at Y_SCALE: y_sub=0, row++.
//   row saturates at ROWS.
//   On i_frame_start: all four counters=0. It has priority over i_line_end and
//   i_pixel_en in the same cycle.
//  Pipeline: i_pixel_en in cycle n samples (col,row) before that cycle's update.
//   Stage 1 reads fb and registers an in_range flag (col<COLS && row<ROWS).
//   Stage 2 sets o_color = in_range ? palette[idx] : bg_color, valid in cycle n+2.
//   o_color holds its value when no pixel_en is in flight.
//  Collisions: a framebuffer write and a scan read of the same address in the same
//   cycle return the old data. A palette write in the same cycle as its stage-2 read
//   also outputs the old colour.
//  Width: address = row*COLS+col, $clog2(COLS*ROWS) bits. Products never overflow.
// TESTING
//  After reset, no writes; frame_start, 1 pixel_en -> o_color=000 at n+2.
//   Ready=1 throughout.
//  SET_PALETTE entry 2=0x123; SET_PIXEL x=0,y=0,idx=2; frame_start; 8 pixel_en ->
//   8 outputs of 0x123. 9th output shows fb[1].
//  FILL idx=1 -> ready=0 for exactly 4800 cycles, then 1. Full scan -> all fff.
//   Valid held during FILL is not accepted.
//  SET_BG 0x0a5 mid-frame -> border unchanged until next frame_start.
//   Then pixels with col>=80 or row>=60 give 0x0a5.
//  SET_PIXEL x=80,y=0 and x=0,y=60 -> no framebuffer change. Opcode 0x3c accepted
//   and ignored.
//  Assert i_reset 100 cycles into FILL -> ready=1 and o_color=0 immediately.
//   The partial fill remains in the framebuffer.

Source files
------------

// File: rtl/scaled_pixel_generator.sv
// Scaled indexed-colour pixel generator: COLS x ROWS framebuffer, palette lookup,
// border colour, and a valid/ready instruction port with a multi-cycle FILL.
module scaled_pixel_generator #(
  parameter int COLS    = 80,
  parameter int ROWS    = 60,
  parameter int BPP     = 3,
  parameter int X_SCALE = 8,
  parameter int Y_SCALE = 8,
  parameter int COLOR_W = 12
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_frame_start,
  input  logic               i_line_end,
  input  logic               i_pixel_en,
  output logic [COLOR_W-1:0] o_color,
  input  logic [31:0]        i_instruction,
  input  logic               i_instruction_valid,
  output logic               o_instruction_ready,
  output logic               state_dbg
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int CW    = $clog2(COLS + 1);
  localparam int RW    = $clog2(ROWS + 1);
  localparam int XW    = (X_SCALE > 1) ? $clog2(X_SCALE) : 1;
  localparam int YW    = (Y_SCALE > 1) ? $clog2(Y_SCALE) : 1;
  localparam int PAL   = 1 << BPP;
  localparam logic [31:0] COLS_U = COLS;
  localparam logic [31:0] ROWS_U = ROWS;

  localparam logic [7:0] OP_SET_BG      = 8'h01;
  localparam logic [7:0] OP_SET_PIXEL   = 8'h07;
  localparam logic [7:0] OP_SET_PALETTE = 8'h08;
  localparam logic [7:0] OP_FILL        = 8'h09;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  function automatic logic [COLOR_W-1:0] default_color(input int i);
    logic [11:0] c;
    case (i)
      0:       c = 12'h000;
      1:       c = 12'hfff;
      2:       c = 12'hf00;
      3:       c = 12'h0f0;
      4:       c = 12'h00f;
      5:       c = 12'hf0f;
      6:       c = 12'h0ff;
      7:       c = 12'hff0;
      default: c = 12'h000;
    endcase
    return COLOR_W'(c);
  endfunction

  state_t             state, state_next;
  logic [AW-1:0]      fill_cnt, fill_cnt_next;
  logic [BPP-1:0]     fill_idx, fill_idx_next;
  logic               fb_we;
  logic [AW-1:0]      fb_waddr;
  logic [BPP-1:0]     fb_wdata;

  logic [BPP-1:0]     fb [CELLS];
  logic [COLOR_W-1:0] palette [PAL];
  logic [COLOR_W-1:0] bg_color, pending_bg;

  logic [XW-1:0]      x_sub;
  logic [CW-1:0]      col;
  logic [YW-1:0]      y_sub;
  logic [RW-1:0]      row;

  logic               s1_valid, s1_in_range;
  logic [BPP-1:0]     s1_idx;

  logic [7:0]         opcode, arg_x, arg_y;
  logic               xfer, pixel_ok, in_range;
  logic [AW-1:0]      pixel_addr, rd_addr;
  logic               unused_ok;

  // Handshake: an instruction transfers on a rising clock edge where
  // i_instruction_valid && o_instruction_ready; ready is high only in IDLE.
  assign xfer      = i_instruction_valid && o_instruction_ready;
  assign opcode    = i_instruction[7:0];
  assign arg_x     = i_instruction[15:8];
  assign arg_y     = i_instruction[23:16];
  assign pixel_ok  = (32'(arg_x) < COLS_U) && (32'(arg_y) < ROWS_U);
  assign pixel_addr = AW'(32'(arg_y) * COLS_U + 32'(arg_x));
  assign in_range  = (32'(col) < COLS_U) && (32'(row) < ROWS_U);
  assign rd_addr   = in_range ? AW'(32'(row) * COLS_U + 32'(col)) : '0;
  assign state_dbg = (state == FILL);
  assign unused_ok = &{1'b0, i_instruction};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      fill_cnt <= '0;
      fill_idx <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= fill_cnt_next;
      fill_idx <= fill_idx_next;
    end
  end

  always_comb begin
    state_next          = state;
    fill_cnt_next       = fill_cnt;
    fill_idx_next       = fill_idx;
    o_instruction_ready = 1'b0;
    fb_we               = 1'b0;
    fb_waddr            = '0;
    fb_wdata            = '0;
    case (state)
      IDLE: begin
        o_instruction_ready = 1'b1;
        if (i_instruction_valid) begin
          if (opcode == OP_SET_PIXEL && pixel_ok) begin
            fb_we    = 1'b1;
            fb_waddr = pixel_addr;
            fb_wdata = i_instruction[24 +: BPP];
          end else if (opcode == OP_FILL) begin
            state_next    = FILL;
            fill_cnt_next = '0;
            fill_idx_next = i_instruction[8 +: BPP];
          end
        end
      end
      FILL: begin
        fb_we    = 1'b1;
        fb_waddr = fill_cnt;
        fb_wdata = fill_idx;
        if (fill_cnt == AW'(CELLS - 1)) begin
          state_next    = IDLE;
          fill_cnt_next = '0;
        end else begin
          fill_cnt_next = fill_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Framebuffer has no reset; the registered read returns old data on a collision.
  always_ff @(posedge i_clk) begin
    if (fb_we) fb[fb_waddr] <= fb_wdata;
    if (i_pixel_en) s1_idx <= fb[rd_addr];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < PAL; i++) palette[i] <= default_color(i);
      pending_bg <= '0;
      bg_color   <= '0;
    end else begin
      if (xfer && opcode == OP_SET_PALETTE)
        palette[i_instruction[20 +: BPP]] <= i_instruction[8 +: COLOR_W];
      if (xfer && opcode == OP_SET_BG)
        pending_bg <= COLOR_W'(i_instruction[19:8]);
      if (i_frame_start) bg_color <= pending_bg;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      x_sub <= '0;
      col   <= '0;
      y_sub <= '0;
      row   <= '0;
    end else if (i_frame_start) begin
      x_sub <= '0;
      col   <= '0;
      y_sub <= '0;
      row   <= '0;
    end else if (i_line_end) begin
      x_sub <= '0;
      col   <= '0;
      if (y_sub == YW'(Y_SCALE - 1)) begin
        y_sub <= '0;
        if (32'(row) != ROWS_U) row <= row + 1'b1;
      end else begin
        y_sub <= y_sub + 1'b1;
      end
    end else if (i_pixel_en) begin
      if (x_sub == XW'(X_SCALE - 1)) begin
        x_sub <= '0;
        if (32'(col) != COLS_U) col <= col + 1'b1;
      end else begin
        x_sub <= x_sub + 1'b1;
      end
    end
  end

  // Stage 1 samples the pre-update scan position; stage 2 resolves the colour.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid    <= 1'b0;
      s1_in_range <= 1'b0;
      o_color     <= '0;
    end else begin
      s1_valid    <= i_pixel_en;
      s1_in_range <= in_range;
      if (s1_valid) o_color <= s1_in_range ? palette[s1_idx] : bg_color;
    end
  end

endmodule

// File: tb/tb_scaled_pixel_generator.sv
// Directed bench for scaled_pixel_generator at default parameters (80x60, 8x8, 3bpp).
`timescale 1ns/1ps
module tb_scaled_pixel_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        line_end = 1'b0;
  logic        pixel_en = 1'b0;
  logic [11:0] color;
  logic [31:0] instr = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];
  logic [1:0]  pen_pipe = 2'b00;

  scaled_pixel_generator dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .i_frame_start       (frame_start),
    .i_line_end          (line_end),
    .i_pixel_en          (pixel_en),
    .o_color             (color),
    .i_instruction       (instr),
    .i_instruction_valid (valid),
    .o_instruction_ready (ready),
    .state_dbg           (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // scoreboard: each pixel_en produces one colour two edges later
  always @(posedge clk) pen_pipe <= {pen_pipe[0], pixel_en};

  always @(negedge clk) begin
    if (pen_pipe[1]) begin
      if (exp_q.size() == 0) check("pixel_unexpected", 32'(color), 32'hffff_ffff);
      else check("pixel", 32'(color), 32'(exp_q.pop_front()));
    end
  end

  // instruction encoders
  function automatic logic [31:0] op_bg(input logic [11:0] c);
    return {12'h000, c, 8'h01};
  endfunction
  function automatic logic [31:0] op_pixel(input logic [7:0] x, input logic [7:0] y, input logic [2:0] idx);
    return {5'h00, idx, y, x, 8'h07};
  endfunction
  function automatic logic [31:0] op_pal(input logic [2:0] entry, input logic [11:0] c);
    return {9'h000, entry, c, 8'h08};
  endfunction
  function automatic logic [31:0] op_fill(input logic [2:0] idx);
    return {21'h000000, idx, 8'h09};
  endfunction

  // driver tasks (all drive at negedge)
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pix(input logic [11:0] e);
    pixel_en = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    pixel_en = 1'b0;
  endtask

  task automatic line_ends(input int n);
    repeat (n) begin
      line_end = 1'b1;
      @(negedge clk);
      line_end = 1'b0;
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] ins);
    instr = ins;
    valid = 1'b1;
    for (int i = 0; i < 6000 && !ready; i++) @(negedge clk);
    check("send_ready", 32'(ready), 32'd1);
    @(negedge clk);
    valid = 1'b0;
    instr = '0;
  endtask

  initial begin
    int cnt;

    // reset
    tick(3);
    check("rst_color", 32'(color), 32'h000);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    tick(2);

    // untouched framebuffer and default palette entry 0
    frame();
    pix(12'h000);
    tick(4);
    check("idle_ready", 32'(ready), 32'd1);

    // palette + pixel write, horizontal scaling
    send(op_pal(3'd2, 12'h123));
    send(op_pixel(8'd0, 8'd0, 3'd2));
    send(op_pixel(8'd1, 8'd0, 3'd3));
    frame();
    repeat (8) pix(12'h123);
    pix(12'h0f0);
    pix(12'h0f0);
    tick(4);
    check("color_hold", 32'(color), 32'h0f0);

    // border colour only changes at frame start
    send(op_bg(12'h0a5));
    line_ends(480);
    pix(12'h000);
    line_ends(40);
    pix(12'h000);
    frame();
    line_ends(480);
    pix(12'h0a5);
    tick(4);
    frame();
    for (int c = 0; c < 80; c++)
      repeat (8) pix(c == 0 ? 12'h123 : (c == 1 ? 12'h0f0 : 12'h000));
    pix(12'h0a5);
    tick(4);

    // out-of-range SET_PIXEL and unknown opcode change nothing
    send(op_pixel(8'd80, 8'd0, 3'd5));
    send(op_pixel(8'd0, 8'd60, 3'd5));
    send({5'h00, 3'd5, 8'd0, 8'd0, 8'h3c});
    check("unknown_ready", 32'(ready), 32'd1);
    frame();
    repeat (8) pix(12'h123);
    line_ends(8);
    repeat (8) pix(12'h000);
    tick(4);

    // palette write colliding with stage-2 read yields old colour
    frame();
    pixel_en = 1'b1;
    exp_q.push_back(12'h123);
    tick();
    instr = op_pal(3'd2, 12'h456);
    valid = 1'b1;
    exp_q.push_back(12'h456);
    tick();
    valid = 1'b0;
    instr = '0;
    pixel_en = 1'b0;
    tick(4);

    // FILL: ready low for exactly COLS*ROWS cycles, held valid is not taken
    send(op_fill(3'd1));
    instr = op_pal(3'd1, 12'h00f);
    valid = 1'b1;
    cnt = 0;
    while (!ready && cnt < 6000) begin
      cnt++;
      if (cnt == 2) check("fill_state", 32'(state_dbg), 32'd1);
      tick();
    end
    valid = 1'b0;
    instr = '0;
    check("fill_len", 32'(cnt), 32'd4800);
    check("fill_ready", 32'(ready), 32'd1);
    frame();
    for (int c = 0; c < 80; c++) repeat (8) pix(12'hfff);
    line_ends(30 * 8);
    for (int c = 0; c < 80; c++) repeat (8) pix(12'hfff);
    line_ends(29 * 8);
    for (int c = 0; c < 80; c++) repeat (8) pix(12'hfff);
    pix(12'h0a5);
    line_ends(8);
    pix(12'h0a5);
    tick(4);

    // reset 100 cycles into a FILL: immediate effect, partial fill kept
    send(op_fill(3'd6));
    tick(100);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_color", 32'(color), 32'h000);
    check("rst_mid_state", 32'(state_dbg), 32'd0);
    tick();
    rst = 1'b0;
    tick(2);
    frame();
    for (int c = 0; c < 80; c++) repeat (8) pix(12'h0ff);
    line_ends(8);
    for (int c = 0; c < 80; c++) repeat (8) pix(c < 20 ? 12'h0ff : 12'hfff);
    tick(6);
    check("final_hold", 32'(color), 32'hfff);
    check("final_ready", 32'(ready), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
